fp_add_pipe: RTL



---
 rtl/fp_add_pkg.sv | 60 ++++++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_add_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared widths, inter-stage register layouts and constants for the pipelined FP adder.
package fp_add_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;
    localparam int FP_TAG_W  = 4;
    localparam int FP_W      = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_BIAS   = (1 << (FP_EXP_W - 1)) - 1;

    // Hidden bit + fraction + guard/round/sticky, and one more bit for the adder carry.
    localparam int FP_EXT_W     = FP_MAN_W + 4;
    localparam int FP_SUM_W     = FP_MAN_W + 5;
    localparam int FP_LZC_W     = $clog2(FP_SUM_W);
    localparam int FP_SHIFT_MAX = FP_MAN_W + 3;
    localparam int FP_EW1       = FP_EXP_W + 1;

    localparam logic [FP_EXP_W-1:0] EXP_ONES = '1;
    localparam logic [FP_W-1:0] QNAN =
        {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

    localparam int FP_FLAG_W = 3;
    localparam int FLAG_INV  = 2;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_INX  = 0;

    typedef struct packed {
        logic                sign;
        logic                zsign;
        logic                eff_sub;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_EXT_W-1:0] ma;
        logic [FP_EXT_W-1:0] mb;
        logic                special;
        logic                spec_inv;
        logic [FP_W-1:0]     spec_val;
        logic [FP_TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic                sign;
        logic                zsign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_SUM_W-1:0] sum;
        logic                special;
        logic                spec_inv;
        logic [FP_W-1:0]     spec_val;
        logic [FP_TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W:0]   exp;
        logic [FP_EXT_W-1:0] m;
        logic                special;
        logic                spec_inv;
        logic [FP_W-1:0]     spec_val;
        logic [FP_TAG_W-1:0] tag;
    } s3_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc
    import fp_add_pkg::*;
#(
    parameter int WIDTH = FP_SUM_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the most significant set bit writes the count last.
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Four-stage floating-point adder/subtractor: align, add, normalize, round/pack.
// A single advance signal stalls every stage together when the output is blocked.
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int TAG_W = FP_TAG_W,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    input  logic                 in_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_s,
    output logic [TAG_W-1:0]     out_tag,
    output logic [FP_FLAG_W-1:0] out_flags
);

    localparam int SH_W = $clog2(FP_EXT_W);

    function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic adv;
    logic vld_p1, vld_p2, vld_p3;
    s1_t  s1_d, s1_p1;
    s2_t  s2_d, s2_p2;
    s3_t  s3_d, s3_p3;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---- S1: unpack, order by magnitude, align the smaller operand, classify specials
    logic                sa, sb, swap, s_big, nan_a, nan_b, inf_a, inf_b, snan_a, snan_b, sticky;
    logic [EXP_W-1:0]    ea, eb, e_big, e_small, ee_big, ee_small, diff;
    logic [MAN_W-1:0]    fa, fb, f_big, f_small;
    logic [FP_EXT_W-1:0] ext_small, mask, shifted;
    logic [SH_W-1:0]     sh1;

    // Align stage: swap so |A| >= |B| and shift B right keeping G/R/S.
    always_comb begin
        sa = in_a[W-1];
        ea = in_a[W-2 -: EXP_W];
        fa = in_a[MAN_W-1:0];
        sb = in_b[W-1] ^ in_sub;
        eb = in_b[W-2 -: EXP_W];
        fb = in_b[MAN_W-1:0];

        swap    = {eb, fb} > {ea, fa};
        s_big   = swap ? sb : sa;
        e_big   = swap ? eb : ea;
        f_big   = swap ? fb : fa;
        e_small = swap ? ea : eb;
        f_small = swap ? fa : fb;

        ee_big   = (e_big   == '0) ? EXP_W'(1) : e_big;
        ee_small = (e_small == '0) ? EXP_W'(1) : e_small;
        diff     = ee_big - ee_small;
        sh1      = (diff > EXP_W'(FP_SHIFT_MAX)) ? SH_W'(FP_SHIFT_MAX) : SH_W'(diff);

        ext_small = {(e_small != '0), f_small, 3'b000};
        mask      = (FP_EXT_W'(1) << sh1) - FP_EXT_W'(1);
        sticky    = |(ext_small & mask);
        shifted   = ext_small >> sh1;

        nan_a  = (ea == '1) && (fa != '0);
        nan_b  = (eb == '1) && (fb != '0);
        inf_a  = (ea == '1) && (fa == '0);
        inf_b  = (eb == '1) && (fb == '0);
        snan_a = nan_a & ~fa[MAN_W-1];
        snan_b = nan_b & ~fb[MAN_W-1];

        s1_d         = '0;
        s1_d.sign    = s_big;
        s1_d.eff_sub = sa ^ sb;
        // An exact zero keeps a negative sign only when both effective operands are negative.
        s1_d.zsign   = ~(sa ^ sb) & s_big;
        s1_d.exp     = ee_big;
        s1_d.ma      = {(e_big != '0), f_big, 3'b000};
        s1_d.mb      = {shifted[FP_EXT_W-1:1], shifted[0] | sticky};
        s1_d.tag     = in_tag;

        if (nan_a | nan_b) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = QNAN;
            s1_d.spec_inv = snan_a | snan_b;
        end else if (inf_a & inf_b & (sa ^ sb)) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = QNAN;
            s1_d.spec_inv = 1'b1;
        end else if (inf_a) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf_b) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // ---- S2: magnitude add or subtract (never negative thanks to the S1 swap)
    // Add stage: mantissa sum with carry bit.
    always_comb begin
        s2_d          = '0;
        s2_d.sign     = s1_p1.sign;
        s2_d.zsign    = s1_p1.zsign;
        s2_d.exp      = s1_p1.exp;
        s2_d.special  = s1_p1.special;
        s2_d.spec_inv = s1_p1.spec_inv;
        s2_d.spec_val = s1_p1.spec_val;
        s2_d.tag      = s1_p1.tag;
        s2_d.sum      = s1_p1.eff_sub ? ({1'b0, s1_p1.ma} - {1'b0, s1_p1.mb})
                                      : ({1'b0, s1_p1.ma} + {1'b0, s1_p1.mb});
    end

    // ---- S3: normalize, clamping the left shift so the exponent stays at or above 1
    logic [FP_LZC_W-1:0] lz;
    logic [FP_EW1-1:0]   need, lim, sh3, exp_n;
    logic [FP_EXT_W-1:0] m_l;

    fp_lzc #(.WIDTH(FP_SUM_W), .CNT_W(FP_LZC_W)) u_lzc (
        .din (s2_p2.sum),
        .cnt (lz)
    );

    // Normalize stage: right shift on carry, otherwise bounded left shift.
    always_comb begin
        s3_d          = '0;
        s3_d.special  = s2_p2.special;
        s3_d.spec_inv = s2_p2.spec_inv;
        s3_d.spec_val = s2_p2.spec_val;
        s3_d.tag      = s2_p2.tag;
        s3_d.sign     = (s2_p2.sum == '0) ? s2_p2.zsign : s2_p2.sign;

        need  = FP_EW1'(lz) - FP_EW1'(1);
        lim   = {1'b0, s2_p2.exp} - FP_EW1'(1);
        sh3   = (need < lim) ? need : lim;
        m_l   = s2_p2.sum[FP_EXT_W-1:0] << sh3;
        exp_n = {1'b0, s2_p2.exp} - sh3;

        if (s2_p2.sum[FP_SUM_W-1]) begin
            s3_d.m   = {s2_p2.sum[FP_SUM_W-1:2], s2_p2.sum[1] | s2_p2.sum[0]};
            s3_d.exp = {1'b0, s2_p2.exp} + FP_EW1'(1);
        end else begin
            s3_d.m   = m_l;
            // Hidden bit still clear after the clamped shift means a denormal (or zero).
            s3_d.exp = m_l[FP_EXT_W-1] ? exp_n : '0;
        end
    end

    // ---- S4: round to nearest even, detect overflow, pack
    logic [MAN_W:0]    mant;
    logic [MAN_W+1:0]  rnd;
    logic [MAN_W-1:0]  frac;
    logic [FP_EW1-1:0] exp4;
    logic              g4, r4, st4, ovf, inexact;
    logic [W-1:0]      res_s;
    logic [FP_FLAG_W-1:0] res_flags;

    // Round/pack stage: final word and exception flags.
    always_comb begin
        mant    = s3_p3.m[FP_EXT_W-1:3];
        g4      = s3_p3.m[2];
        r4      = s3_p3.m[1];
        st4     = s3_p3.m[0];
        inexact = g4 | r4 | st4;
        rnd     = {1'b0, mant} + (MAN_W+2)'(rne_inc(mant[0], g4, r4, st4));
        exp4    = s3_p3.exp;
        frac    = rnd[MAN_W-1:0];
        if (rnd[MAN_W+1]) begin
            exp4 = exp4 + FP_EW1'(1);
            frac = rnd[MAN_W:1];
        end else if ((exp4 == '0) && rnd[MAN_W]) begin
            // A denormal rounded up into the smallest normal.
            exp4 = FP_EW1'(1);
        end
        ovf = exp4 >= {1'b0, EXP_ONES};

        res_s               = {s3_p3.sign, exp4[EXP_W-1:0], frac};
        res_flags           = '0;
        res_flags[FLAG_INX] = inexact;
        if (s3_p3.special) begin
            res_s               = s3_p3.spec_val;
            res_flags           = '0;
            res_flags[FLAG_INV] = s3_p3.spec_inv;
        end else if (ovf) begin
            res_s               = {s3_p3.sign, EXP_ONES, {MAN_W{1'b0}}};
            res_flags[FLAG_OVF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end
    end

    // Stage valid bits: cleared by reset, shifted forward on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Stage data registers: load on advance, bubbles included.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_p1 <= s1_d;
            s2_p2 <= s2_d;
            s3_p3 <= s3_d;
        end
    end

    // Output register: cleared by reset, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv) begin
            out_valid <= vld_p3;
            out_s     <= res_s;
            out_tag   <= s3_p3.tag;
            out_flags <= res_flags;
        end
    end

endmodule
